div_cmd_arbiter: RTL

//  Shares the divider register-command bus (cmd_opt/cmd_addr/cmd_data/cmd_rdata) among NUM_REQ

---
 rtl/div_arb_pkg.sv | 20 ++
 rtl/div_rr_picker.sv | 39 +++
 rtl/div_cmd_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/div_arb_pkg.sv
// rtl/div_arb_pkg.sv - state and register-bus command encodings for the divider command arbiter
package div_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } arb_state_e;

   localparam logic [1:0] CMD_IDLE  = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   // Only READ and WRITE reach the register bus; IDLE and 2'b11 complete with an error.
   function automatic logic cmd_is_legal(input logic [1:0] cmd);
      return (cmd == CMD_READ) || (cmd == CMD_WRITE);
   endfunction

endpackage

// File: rtl/div_rr_picker.sv
// rtl/div_rr_picker.sv - rotate/priority-encode of requests starting at a pointer
module div_rr_picker
   import div_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx
);

   logic             found;
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] pos;

   // Scan ptr, ptr+1, ... with wrap-around and keep the first requester found.
   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      sum    = '0;
      pos    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         pos = sum[IDX_W-1:0];
         if (!found && req[pos]) begin
            found       = 1'b1;
            onehot[pos] = 1'b1;
            idx         = pos;
         end
      end
   end

endmodule

// File: rtl/div_cmd_arbiter.sv
// rtl/div_cmd_arbiter.sv - shares the divider register bus one access at a time; DIV_ARB_FIXED_PRIO_EN selects fixed priority
module div_cmd_arbiter
   import div_arb_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*2-1:0]          req_cmd_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic [NUM_REQ-1:0]            done_o,
   output logic [DATA_WIDTH-1:0]         rdata_o,
   output logic                          err_o,
   output logic [1:0]                    cmd_opt_o,
   output logic [ADDR_WIDTH-1:0]         cmd_addr_o,
   output logic [DATA_WIDTH-1:0]         cmd_data_o,
   input  logic [DATA_WIDTH-1:0]         cmd_rdata_i
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_e              state;
   arb_state_e              state_nxt;
   logic [NUM_REQ-1:0]      win_onehot;
   logic [IDX_W-1:0]        win_idx;
   logic [IDX_W-1:0]        rr_ptr;
   logic [IDX_W-1:0]        cur_idx;
   logic [1:0]              cur_cmd;
   logic                    cur_err;
   logic [1:0]              sel_cmd;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;

   div_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req    (req_i),
      .ptr    (rr_ptr),
      .onehot (win_onehot),
      .idx    (win_idx)
   );

`ifdef DIV_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   // Move the search start just past the requester that was served.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (state == ST_DONE) begin
         rr_ptr <= (cur_idx == IDX_W'(NUM_REQ-1)) ? '0 : cur_idx + IDX_W'(1);
      end
   end
`endif

   // Select the winner's command fields with an AND-OR mux on the one-hot grant.
   always_comb begin
      sel_cmd   = CMD_IDLE;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_onehot[i]) begin
            sel_cmd   = req_cmd_i[i*2 +: 2];
            sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: every accepted request walks a fixed four-cycle sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (|req_i) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Latch the winner at grant; the bus registers themselves hold addr/data through ISSUE.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         gnt_o      <= '0;
         done_o     <= '0;
         rdata_o    <= '0;
         err_o      <= 1'b0;
         cmd_opt_o  <= CMD_IDLE;
         cmd_addr_o <= '0;
         cmd_data_o <= '0;
         cur_idx    <= '0;
         cur_cmd    <= CMD_IDLE;
         cur_err    <= 1'b0;
      end else begin
         gnt_o      <= '0;
         done_o     <= '0;
         err_o      <= 1'b0;
         cmd_opt_o  <= CMD_IDLE;
         cmd_addr_o <= '0;
         cmd_data_o <= '0;
         case (state)
            ST_IDLE: begin
               if (|req_i) begin
                  gnt_o   <= win_onehot;
                  cur_idx <= win_idx;
                  cur_cmd <= sel_cmd;
                  cur_err <= !cmd_is_legal(sel_cmd);
                  if (cmd_is_legal(sel_cmd)) begin
                     cmd_opt_o  <= sel_cmd;
                     cmd_addr_o <= sel_addr;
                     cmd_data_o <= sel_wdata;
                  end
               end
            end
            ST_WAIT: begin
               rdata_o <= (cur_cmd == CMD_READ) ? cmd_rdata_i : '0;
               done_o  <= NUM_REQ'(1) << cur_idx;
               err_o   <= cur_err;
            end
            ST_DONE: begin
               rdata_o <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
